// File: rtl/uart_rx_buffered_if.sv
// rtl/uart_rx_buffered_if.sv - pull-handshake bundle between the UART receive FIFO and its consumer
interface uart_rx_buffered_if;
    logic       req_data;
    logic [7:0] data_out;
    logic       pending_data;
    logic       parity_error;
    logic       frame_error;
    logic       overrun;

    modport master (
        input  req_data,
        output data_out,
        output pending_data,
        output parity_error,
        output frame_error,
        output overrun
    );

    modport slave (
        output req_data,
        input  data_out,
        input  pending_data,
        input  parity_error,
        input  frame_error,
        input  overrun
    );
endinterface

// File: rtl/uart_rx_buffered.sv
// rtl/uart_rx_buffered.sv - UART receiver with parity/stop checking and a small pull-style receive FIFO
module uart_rx_buffered #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx,
    uart_rx_buffered_if.master bus
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int LVL_W        = PTR_W + 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(FIFO_DEPTH);
    localparam logic             ODD       = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic             rx_meta;
    logic             rxs;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             perr;
    logic             armed;

    logic [9:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    logic             overrun_r;

    logic             sample;
    logic             push;
    logic             pop;
    logic             full;
    logic             accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // START waits half a bit so every later sample lands mid-bit
    assign sample = (cnt == ((state == S_START) ? HALF_LAST : BIT_LAST));
    assign push   = (state == S_STOP) && sample;
    assign pop    = bus.req_data && (level != '0);
    assign full   = (level == FULL_LVL);
    assign accept = push && (!full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            perr    <= 1'b0;
            armed   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (rxs) begin
                        armed <= 1'b1;
                    end else if (armed) begin
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (sample) begin
                        cnt <= '0;
                        if (rxs) begin
                            state <= S_IDLE;
                        end else begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                            perr    <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (sample) begin
                        cnt   <= '0;
                        shift <= {rxs, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_PARITY: begin
                    if (sample) begin
                        cnt   <= '0;
                        perr  <= ((^shift) ^ rxs) != ODD;
                        state <= S_STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (sample) begin
                        cnt   <= '0;
                        // a low stop bit leaves the line unarmed so it cannot retrigger
                        armed <= rxs;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // when full, a simultaneous pop frees the slot the write lands in
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            overrun_r <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            overrun_r <= push && full && !pop;
            if (accept) begin
                mem[wr_ptr] <= {~rxs, perr, shift};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({accept, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    assign bus.data_out     = mem[rd_ptr][7:0];
    assign bus.parity_error = mem[rd_ptr][8];
    assign bus.frame_error  = mem[rd_ptr][9];
    assign bus.pending_data = (level != '0);
    assign bus.overrun      = overrun_r;
endmodule
